// File: rtl/spi_slave_xcvr.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_xcvr
//   Mode-0 SPI responder. SCK, SS_n and MOSI are oversampled in the clk domain
//   through two-flop synchronizers. A third SCK/SS_n stage provides edge strobes.
//   Received words appear on rx_data with a one-cycle rx_valid pulse. Transmit
//   words are queued through a single-entry holding register (tx_wr / tx_full).
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   sck, ss_n    SPI clock (idle low) and active-low select, asynchronous
//   mosi         serial data in, asynchronous
//   miso         serial data out, 0 whenever not selected
//   tx_data      word to transmit; tx_wr writes it when tx_full is low
//   tx_full      holding register occupied
//   tx_underrun  pulse: a word load found the holding register empty
//   rx_data      last complete received word; rx_valid pulses when it updates
//   frame_err    pulse: ss_n rose with a partial word
//   active       high while a frame is selected (ACTIVE state)
// -----------------------------------------------------------------------------
module spi_slave_xcvr #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              active
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              state_r;
    logic [2:0]          sck_sync_r;
    logic [2:0]          ss_sync_r;
    logic [1:0]          mosi_sync_r;
    logic [DATA_W-1:0]   hold_r;
    logic [DATA_W-1:0]   tx_shift_r;
    logic [DATA_W-2:0]   rx_shift_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                reload_pend_r;
    logic                word_done_r;

    logic                sck_rise_s;
    logic                sck_fall_s;
    logic                ss_fall_s;
    logic                ss_rise_s;
    logic                load_s;
    logic [DATA_W-1:0]   load_word_s;

    // Pin synchronizers; ss_n stages reset high so reset release is not seen as a select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_r  <= 3'b000;
            ss_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
        end else begin
            sck_sync_r  <= {sck_sync_r[1:0], sck};
            ss_sync_r   <= {ss_sync_r[1:0], ss_n};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
        end
    end

    // Edge strobes compare the second and third stages; mosi_sync_r[1] lines up with them.
    always_comb begin
        sck_rise_s = sck_sync_r[1] & ~sck_sync_r[2];
        sck_fall_s = ~sck_sync_r[1] & sck_sync_r[2];
        ss_fall_s  = ~ss_sync_r[1] & ss_sync_r[2];
        ss_rise_s  = ss_sync_r[1] & ~ss_sync_r[2];
    end

    // A word load happens at frame start and on the SCK fall after each completed word.
    always_comb begin
        load_s = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = ss_fall_s;
        end else if (ss_rise_s) begin
            load_s = 1'b0;
        end else begin
            load_s = sck_fall_s & reload_pend_r;
        end
        if (tx_full) begin
            load_word_s = hold_r;
        end else begin
            load_word_s = {DATA_W{1'b0}};
        end
    end

    // Holding register: a load empties it; a write is accepted only if it was empty at sample time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r      <= {DATA_W{1'b0}};
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load_s & ~tx_full;
            if (load_s && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_wr && !tx_full) begin
                hold_r  <= tx_data;
                tx_full <= 1'b1;
            end else begin
                tx_full <= tx_full;
            end
        end
    end

    // Frame FSM with shift registers, bit counter and receive strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            active        <= 1'b0;
            tx_shift_r    <= {DATA_W{1'b0}};
            rx_shift_r    <= {(DATA_W-1){1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            reload_pend_r <= 1'b0;
            word_done_r   <= 1'b0;
            rx_data       <= {DATA_W{1'b0}};
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            rx_valid    <= word_done_r;
            frame_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r         <= {CNT_W{1'b0}};
                    reload_pend_r <= 1'b0;
                    if (ss_fall_s) begin
                        state_r    <= ST_ACTIVE;
                        active     <= 1'b1;
                        tx_shift_r <= load_word_s;
                    end else begin
                        state_r <= ST_IDLE;
                        active  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise_s) begin
                        // Deselect wins over any coincident SCK edge; a partial word is dropped.
                        state_r       <= ST_IDLE;
                        active        <= 1'b0;
                        cnt_r         <= {CNT_W{1'b0}};
                        reload_pend_r <= 1'b0;
                        frame_err     <= (cnt_r != {CNT_W{1'b0}});
                    end else if (sck_rise_s) begin
                        rx_shift_r <= {rx_shift_r[DATA_W-3:0], mosi_sync_r[1]};
                        if (cnt_r == LAST_BIT) begin
                            rx_data       <= {rx_shift_r, mosi_sync_r[1]};
                            word_done_r   <= 1'b1;
                            cnt_r         <= {CNT_W{1'b0}};
                            reload_pend_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else if (sck_fall_s) begin
                        if (reload_pend_r) begin
                            tx_shift_r    <= load_word_s;
                            reload_pend_r <= 1'b0;
                        end else begin
                            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    active  <= 1'b0;
                end
            endcase
        end
    end

    // Registered serial output, forced low outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso <= 1'b0;
        end else begin
            miso <= (state_r == ST_ACTIVE) & tx_shift_r[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
`timescale 1ns/1ps
module tb_spi_slave_xcvr;

    localparam int DW   = 8;
    localparam int HALF = 8;   // clk cycles per SCK half period (16x oversampling)

    logic          clk = 1'b0;
    logic          rst;
    logic          sck;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic [DW-1:0] tx_data;
    logic          tx_wr;
    logic          tx_full;
    logic          tx_underrun;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          active;

    int n_total = 0;
    int n_bad   = 0;

    int            rxv_cnt  = 0;
    int            urun_cnt = 0;
    int            ferr_cnt = 0;
    logic [DW-1:0] rxq[$];

    always #5 clk = ~clk;

    spi_slave_xcvr #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .tx_underrun (tx_underrun),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .active      (active)
    );

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rxq.push_back(rx_data);
        end
        if (tx_underrun) urun_cnt <= urun_cnt + 1;
        if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rxq_at(input int i);
        if (i < rxq.size()) return 32'(rxq[i]);
        else                return 32'hDEADBEEF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [DW-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        tick(1);
        tx_wr   = 1'b0;
    endtask

    task automatic ss_down();
        ss_n = 1'b0;
        tick(HALF);
    endtask

    task automatic ss_up();
        tick(HALF);
        ss_n = 1'b1;
        tick(HALF);
    endtask

    // Mode-0 initiator: drive MOSI while SCK low, sample MISO at the rising edge.
    task automatic shift_bits(input logic [31:0] out_bits, input int nbits, output logic [31:0] in_bits);
        in_bits = 32'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = out_bits[i];
            tick(HALF);
            sck = 1'b1;
            in_bits = {in_bits[30:0], miso};
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] got;
        int base;
        int u0;
        int f0;

        rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_wr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check_val("rst miso",     32'(miso),        32'h0);
        check_val("rst tx_full",  32'(tx_full),     32'h0);
        check_val("rst underrun", 32'(tx_underrun), 32'h0);
        check_val("rst rx_data",  32'(rx_data),     32'h0);
        check_val("rst rx_valid", 32'(rx_valid),    32'h0);
        check_val("rst frame_err",32'(frame_err),   32'h0);
        check_val("rst active",   32'(active),      32'h0);

        // 1: preloaded A5 out, 3C in
        write_tx(8'hA5);
        check_val("t1 full after wr", 32'(tx_full), 32'h1);
        base = rxq.size(); u0 = urun_cnt;
        ss_down();
        check_val("t1 full after load", 32'(tx_full), 32'h0);
        check_val("t1 active", 32'(active), 32'h1);
        check_val("t1 no underrun", 32'(urun_cnt - u0), 32'h0);
        shift_bits(32'h3C, 8, got);
        check_val("t1 miso", got, 32'hA5);
        ss_up();
        check_val("t1 rx count", 32'(rxq.size() - base), 32'h1);
        check_val("t1 rx word", rxq_at(base), 32'h3C);
        check_val("t1 rx_data", 32'(rx_data), 32'h3C);

        // 2: two words under one select, no gap bit
        write_tx(8'h81);
        base = rxq.size();
        ss_down();
        check_val("t2 full dropped", 32'(tx_full), 32'h0);
        write_tx(8'h7E);
        shift_bits(32'h1234, 16, got);
        check_val("t2 miso", got, 32'h817E);
        ss_up();
        check_val("t2 rx count", 32'(rxq.size() - base), 32'h2);
        check_val("t2 rx word0", rxq_at(base), 32'h12);
        check_val("t2 rx word1", rxq_at(base + 1), 32'h34);

        // 3: nothing queued -> zeros and one underrun at frame start
        base = rxq.size(); u0 = urun_cnt;
        ss_down();
        check_val("t3 underrun at start", 32'(urun_cnt - u0), 32'h1);
        shift_bits(32'hFF, 8, got);
        check_val("t3 miso", got, 32'h0);
        ss_up();
        check_val("t3 rx word", rxq_at(base), 32'hFF);

        // 4: abort after 5 rising edges
        base = rxq.size(); f0 = ferr_cnt;
        ss_down();
        shift_bits(32'h15, 5, got);
        ss_up();
        check_val("t4 frame_err", 32'(ferr_cnt - f0), 32'h1);
        check_val("t4 no rx_valid", 32'(rxq.size() - base), 32'h0);
        check_val("t4 rx_data kept", 32'(rx_data), 32'hFF);
        check_val("t4 active", 32'(active), 32'h0);
        ss_down();
        shift_bits(32'h5A, 8, got);
        ss_up();
        check_val("t4 next frame", rxq_at(base), 32'h5A);
        check_val("t4 no extra err", 32'(ferr_cnt - f0), 32'h1);

        // 5a: write while full is dropped
        write_tx(8'hAA);
        write_tx(8'h55);
        ss_down();
        shift_bits(32'h00, 8, got);
        check_val("t5 miso AA", got, 32'hAA);
        ss_up();
        check_val("t5 full after", 32'(tx_full), 32'h0);

        // 5b: write coincident with frame-start load while empty
        u0 = urun_cnt;
        tx_data = 8'h33;
        ss_n = 1'b0;
        tick(2);
        tx_wr = 1'b1;
        tick(1);
        tx_wr = 1'b0;
        tick(HALF - 3);
        check_val("t5 coinc underrun", 32'(urun_cnt - u0), 32'h1);
        check_val("t5 coinc full", 32'(tx_full), 32'h1);
        shift_bits(32'h0000, 16, got);
        check_val("t5 coinc miso", got, 32'h0033);
        ss_up();

        // 6: reset in the middle of a frame
        write_tx(8'h99);
        ss_down();
        write_tx(8'h66);
        shift_bits(32'h5, 3, got);
        f0 = ferr_cnt;
        rst = 1'b1;
        #1;
        check_val("t6 miso",      32'(miso),      32'h0);
        check_val("t6 tx_full",   32'(tx_full),   32'h0);
        check_val("t6 rx_data",   32'(rx_data),   32'h0);
        check_val("t6 rx_valid",  32'(rx_valid),  32'h0);
        check_val("t6 active",    32'(active),    32'h0);
        check_val("t6 underrun",  32'(tx_underrun), 32'h0);
        sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        base = rxq.size();
        ss_down();
        shift_bits(32'hC3, 8, got);
        ss_up();
        check_val("t6 rx word", rxq_at(base), 32'hC3);
        check_val("t6 rx_data", 32'(rx_data), 32'hC3);
        check_val("t6 no frame_err", 32'(ferr_cnt - f0), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
